// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
// Single-clock FIFO with arbitrary (non power-of-two) depth, optional
// first-word-fall-through read, run-time almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow capture and a synchronous flush.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    // write side
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  overflow_o,
    // read side
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic                  underflow_o,
    // thresholds and status
    input  logic [CNT_WIDTH-1:0]  afull_thresh_i,
    input  logic [CNT_WIDTH-1:0]  aempty_thresh_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [1:0]            err_sticky_o
);

    // Pointer advance with an explicit wrap at DEPTH-1, so any depth works.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        if (p == ADDR_WIDTH'(DEPTH - 1)) begin
            return '0;
        end
        return p + ADDR_WIDTH'(1);
    endfunction

    // Storage is deliberately not reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_ovf;
    logic                  r_udf;
    logic [1:0]            r_err;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_wr_rej;
    logic w_rd_rej;

    // Status is decoded from the registered count only.
    assign w_full  = (r_count == CNT_WIDTH'(DEPTH));
    assign w_empty = (r_count == '0);

    // A flush swallows any access in the same cycle, including the error pulses.
    // A write into a full FIFO still goes through when a read frees the slot
    // on the same edge (the read sees the old head since memory updates later).
    assign w_rd_acc = rd_en_i & ~w_empty & ~clr_i;
    assign w_wr_acc = wr_en_i & (~w_full | w_rd_acc) & ~clr_i;
    assign w_wr_rej = wr_en_i & ~w_wr_acc & ~clr_i;
    assign w_rd_rej = rd_en_i & w_empty & ~clr_i;

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    // Write/read pointers, cleared by reset or flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd_acc) r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
    end

    // Occupancy: moves only when exactly one side is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle reject pulses plus sticky capture; stickies drop only on flush/reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_err <= 2'b00;
        end else begin
            r_ovf <= w_wr_rej;
            r_udf <= w_rd_rej;
            if (clr_i) begin
                r_err <= 2'b00;
            end else begin
                r_err <= r_err | {w_wr_rej, w_rd_rej};
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is shown directly; zero while empty.
            assign rd_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
            assign rd_valid_o = ~w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            // Registered read: data lands one cycle after the accepted read
            // and is held until the next one; valid pulses for that cycle.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (clr_i) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign rd_data_o  = r_rd_data;
            assign rd_valid_o = r_rd_valid;
        end
    endgenerate

    // Thresholds are compared live so a threshold change shows immediately.
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (r_count >= afull_thresh_i);
    assign almost_empty_o = (r_count <= aempty_thresh_i);
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_udf;
    assign count_o        = r_count;
    assign err_sticky_o   = r_err;

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO, successor to the basic sync FIFO.
- Adds non-power-of-two depth, a selectable first-word-fall-through (FWFT) read mode, run-time almost-full/almost-empty thresholds, an occupancy count, sticky error capture and a synchronous flush.
- Sits between producer/consumer datapath blocks in one clock domain.

Parameters:
DATA_WIDTH, 8, word width in bits.
DEPTH, 16, number of entries; any integer >= 2 (power of two not required).
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
ADDR_WIDTH, $clog2(DEPTH), pointer width.
CNT_WIDTH, $clog2(DEPTH+1), occupancy/threshold width.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
clr_i  input  1  synchronous flush.
wr_en_i  input  1  write request.
wr_data_i  input  DATA_WIDTH  write data.
full_o  output  1  count == DEPTH.
almost_full_o  output  1  count >= afull_thresh_i.
overflow_o  output  1  one-cycle pulse, write rejected.
rd_en_i  input  1  read request (pop/ack in FWFT).
rd_data_o  output  DATA_WIDTH  read data.
rd_valid_o  output  1  rd_data_o holds valid popped/head data.
empty_o  output  1  count == 0.
almost_empty_o  output  1  count <= aempty_thresh_i.
underflow_o  output  1  one-cycle pulse, read rejected.
afull_thresh_i  input  CNT_WIDTH  almost-full threshold.
aempty_thresh_i  input  CNT_WIDTH  almost-empty threshold.
count_o  output  CNT_WIDTH  current occupancy.
err_sticky_o  output  2  [1] overflow seen, [0] underflow seen.

Behaviour:
- Single clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset (rst_ni=0): pointers, count, rd_data_o, rd_valid_o, overflow_o, underflow_o, err_sticky_o = 0; empty_o=1; full_o=0; almost_empty_o=1; almost_full_o = (afull_thresh_i==0). Storage array is not reset. Reset mid-operation discards all contents.
- Write accepted at posedge when wr_en_i & (!full | rd accepted same edge); mem[wr_ptr] <= wr_data_i, wr_ptr advances.
- Read accepted at posedge when rd_en_i & !empty; rd_ptr advances.
- Pointers wrap from DEPTH-1 to 0 (explicit compare, no modulo-2^N).
- count_o is registered: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags are decoded combinationally from the registered count, so they change in the cycle after the accepted access.
- Thresholds are sampled live; changing them changes the almost flags in the same cycle.
- Standard mode (FWFT=0):
  - rd_data_o <= mem[rd_ptr] on an accepted read; data is visible one cycle after the edge.
  - rd_valid_o pulses high for that one cycle.
  - rd_data_o holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data_o = mem[rd_ptr] whenever !empty_o, and rd_valid_o = !empty_o.
  - rd_en_i pops the head; the next head appears the cycle after the pop.
  - A write into an empty FIFO is visible on rd_data_o the cycle after the write edge.
- Full, wr_en_i & rd_en_i: both accepted, count stays DEPTH. Read returns the old head (read-before-write), no overflow.
- Empty, wr_en_i & rd_en_i: write accepted, read rejected. underflow_o pulses and count becomes 1.
- Rejected write (full, no read): data dropped, pointers unchanged. overflow_o = 1 for exactly the next cycle; err_sticky_o[1] set.
- Rejected read (empty): pointers unchanged. underflow_o = 1 for the next cycle; err_sticky_o[0] set.
- Back-to-back rejects give back-to-back pulses.
- clr_i: at the edge, pointers, count, err_sticky_o, rd_valid_o = 0 and rd_data_o = 0. clr_i overrides wr_en_i/rd_en_i in the same cycle; those accesses are dropped with no overflow/underflow. Sticky bits clear only on clr_i or reset.

Test Plan:
1. DEPTH=12, FWFT=0: write 12 words 0x01..0x0C, then read 12 -> full_o=1 after 12th write; rd_data_o returns 0x01..0x0C in order, one per cycle after each read edge; empty_o=1 at end; pointers wrap cleanly on a second 12-word pass.
2. DEPTH=16, afull_thresh_i=14, aempty_thresh_i=2: write 14 words -> almost_full_o rises exactly when count_o=14. Read 12 words -> almost_empty_o rises when count_o=2. Change afull_thresh_i to 1 while count_o=2 -> almost_full_o=1 the same cycle.
3. Write 17 words into DEPTH=16 -> overflow_o is a single-cycle pulse after the 17th edge, err_sticky_o=2'b10, the 17th word is absent on readback. Write 2 words, read 3 -> underflow_o pulse, err_sticky_o=2'b11.
4. Full FIFO (head 0xA5), then wr_en_i=rd_en_i=1 with data 0x3C -> rd_data_o=0xA5, count_o stays 16, no overflow; 0x3C is read last. Empty FIFO with wr=rd=1 -> underflow pulse, count_o=1.
5. FWFT=1, write 0x55 into empty FIFO -> one cycle later rd_valid_o=1, rd_data_o=0x55 with no rd_en_i. Pulse rd_en_i -> empty_o=1 and rd_valid_o=0 next cycle.
6. Count 7 with err_sticky_o=2'b01: assert clr_i together with wr_en_i -> next cycle count_o=0, empty_o=1, err_sticky_o=0, no overflow. Assert rst_ni=0 mid-burst asynchronously -> outputs take reset values before the next clock edge.
